// File: rtl/spi_frame_receiver.sv
// SPI peripheral receiver for the 40-bit write frame (preamble, address, control, data), MSB first.
// Define SPI_RX_STRICT_HDR_EN to reject frames whose preamble or control byte does not match.
module spi_frame_receiver #(
    parameter int          FRAME_BITS  = 40,
    parameter logic [7:0]  PREAMBLE    = 8'hFF,
    parameter logic [7:0]  CTRL_BYTE   = 8'h01,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        spi_cs_l,
    input  logic        spi_sclk,
    input  logic        spi_data,
    output logic [15:0] rx_addr,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_error,
    output logic [1:0]  err_code,
    output logic [5:0]  counter
);

`ifdef SPI_RX_STRICT_HDR_EN
    localparam bit STRICT_HDR = 1'b1;
`else
    localparam bit STRICT_HDR = 1'b0;
`endif

    localparam logic [5:0] LAST_BIT = 6'(FRAME_BITS - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, CHECK, WAIT_CS} state_t;

    state_t                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0]  sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0]  data_sync_q, data_sync_d;
    logic                    sclk_prev_q, sclk_prev_d;
    logic                    rise_q, rise_d;
    logic                    bit_q, bit_d;
    logic [FRAME_BITS-1:0]   shift_q, shift_d;
    logic [5:0]              count_q, count_d;
    logic [15:0]             addr_q, addr_d;
    logic [7:0]              data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    error_q, error_d;
    logic [1:0]              err_code_q, err_code_d;

    logic cs_s, sclk_s, data_s, header_ok;

    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign data_s = data_sync_q[SYNC_STAGES-1];

    assign header_ok = !STRICT_HDR ||
                       ((shift_q[39:32] == PREAMBLE) && (shift_q[15:8] == CTRL_BYTE));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cs_sync_q   <= '1;
            sclk_sync_q <= '0;
            data_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            rise_q      <= 1'b0;
            bit_q       <= 1'b0;
            shift_q     <= '0;
            count_q     <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            error_q     <= 1'b0;
            err_code_q  <= '0;
        end else begin
            state_q     <= state_d;
            cs_sync_q   <= cs_sync_d;
            sclk_sync_q <= sclk_sync_d;
            data_sync_q <= data_sync_d;
            sclk_prev_q <= sclk_prev_d;
            rise_q      <= rise_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            count_q     <= count_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            error_q     <= error_d;
            err_code_q  <= err_code_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!cs_s) state_d = SHIFT;
            SHIFT: begin
                if (rise_q) begin
                    if (count_q == LAST_BIT) state_d = CHECK;
                end else if (cs_s) begin
                    state_d = IDLE;
                end
            end
            CHECK:   state_d = WAIT_CS;
            WAIT_CS: if (cs_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The sclk edge is registered together with its data bit, so the frame
    // decode lands one cycle after the synchronised edge.
    always_comb begin
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_l};
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
        data_sync_d = {data_sync_q[SYNC_STAGES-2:0], spi_data};
        sclk_prev_d = sclk_s;
        rise_d      = sclk_s & ~sclk_prev_q;
        bit_d       = data_s;
        shift_d     = shift_q;
        count_d     = count_q;
        addr_d      = addr_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        error_d     = 1'b0;
        err_code_d  = err_code_q;
        case (state_q)
            IDLE: count_d = '0;
            SHIFT: begin
                if (rise_q) begin
                    shift_d = {shift_q[FRAME_BITS-2:0], bit_q};
                    count_d = count_q + 6'd1;
                end else if (cs_s) begin
                    count_d = '0;
                    if (count_q != '0) begin
                        error_d    = 1'b1;
                        err_code_d = 2'b01;
                    end
                end
            end
            CHECK: begin
                if (header_ok) begin
                    addr_d     = shift_q[31:16];
                    data_d     = shift_q[7:0];
                    valid_d    = 1'b1;
                    err_code_d = 2'b00;
                end else begin
                    error_d    = 1'b1;
                    err_code_d = 2'b10;
                end
            end
            WAIT_CS: if (cs_s) count_d = '0;
            default: count_d = '0;
        endcase
    end

    always_comb begin
        rx_addr  = addr_q;
        rx_data  = data_q;
        rx_valid = valid_q;
        rx_error = error_q;
        err_code = err_code_q;
        counter  = count_q;
    end

endmodule

// File: tb/tb_spi_frame_receiver.sv
// Directed bench for spi_frame_receiver: drives SPI frames with a 4-clk sclk period and
// checks pulses, captured fields, error codes, counter and pulse latency.
module tb_spi_frame_receiver;

    logic        clk = 1'b0;
    logic        reset;
    logic        spi_cs_l;
    logic        spi_sclk;
    logic        spi_data;
    logic [15:0] rx_addr;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_error;
    logic [1:0]  err_code;
    logic [5:0]  counter;

    int check_cnt = 0;
    int pass_cnt  = 0;
    int valid_cnt = 0;
    int error_cnt = 0;
    int both_cnt  = 0;
    int cyc       = 0;
    int rise_cyc  = 0;
    int last_lat  = 0;
    int exp_v     = 0;
    int exp_e     = 0;
    logic [15:0] vaddr [0:15];
    logic [7:0]  vdata [0:15];

    spi_frame_receiver dut (
        .clk      (clk),
        .reset    (reset),
        .spi_cs_l (spi_cs_l),
        .spi_sclk (spi_sclk),
        .spi_data (spi_data),
        .rx_addr  (rx_addr),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_error (rx_error),
        .err_code (err_code),
        .counter  (counter)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: every clk cycle a pulse is high counts once, so a stretched pulse shows up.
    always @(negedge clk) begin
        if (rx_valid && rx_error) both_cnt++;
        if (rx_valid) begin
            if (valid_cnt < 16) begin
                vaddr[valid_cnt] = rx_addr;
                vdata[valid_cnt] = rx_data;
            end
            valid_cnt++;
            last_lat = cyc - rise_cyc;
        end
        if (rx_error) begin
            error_cnt++;
            last_lat = cyc - rise_cyc;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_cnt++;
        if (observed === expected) pass_cnt++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic [43:0] bits, input int nbits);
        spi_cs_l = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            spi_data = bits[43-i];
            spi_sclk = 1'b0;
            repeat (2) @(negedge clk);
            spi_sclk = 1'b1;
            if (i == 39) rise_cyc = cyc;
            repeat (2) @(negedge clk);
        end
        spi_sclk = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic endFrame(input int gap);
        spi_cs_l = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    // Pulse is SYNC_STAGES+2 = 4 edges after the edge sampling the 40th rise,
    // which is 5 edges after the negedge where the rise was driven.
    localparam int EXP_LAT = 5;

    initial begin
        reset    = 1'b1;
        spi_cs_l = 1'b1;
        spi_sclk = 1'b0;
        spi_data = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_addr",     32'(rx_addr),  32'h0);
        checkOutput("reset_data",     32'(rx_data),  32'h0);
        checkOutput("reset_valid",    32'(rx_valid), 32'h0);
        checkOutput("reset_error",    32'(rx_error), 32'h0);
        checkOutput("reset_err_code", 32'(err_code), 32'h0);
        checkOutput("reset_counter",  32'(counter),  32'h0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        $display("[TB] good frame FF_1234_01_A5");
        applyStimulus({40'hFF_1234_01_A5, 4'h0}, 40);
        repeat (4) @(negedge clk);
        exp_v++;
        checkOutput("f1_valid_cnt", 32'(valid_cnt), 32'(exp_v));
        checkOutput("f1_error_cnt", 32'(error_cnt), 32'(exp_e));
        checkOutput("f1_addr",      32'(rx_addr),   32'h1234);
        checkOutput("f1_data",      32'(rx_data),   32'hA5);
        checkOutput("f1_latency",   32'(last_lat),  32'(EXP_LAT));
        checkOutput("f1_count_40",  32'(counter),   32'd40);
        endFrame(6);
        checkOutput("f1_count_0",   32'(counter),   32'd0);

        $display("[TB] short frame of 17 bits");
        applyStimulus({40'hFF_9999_01_99, 4'h0}, 17);
        endFrame(8);
        exp_e++;
        checkOutput("short_error_cnt", 32'(error_cnt), 32'(exp_e));
        checkOutput("short_valid_cnt", 32'(valid_cnt), 32'(exp_v));
        checkOutput("short_err_code",  32'(err_code),  32'h1);
        checkOutput("short_addr",      32'(rx_addr),   32'h1234);
        checkOutput("short_data",      32'(rx_data),   32'hA5);
        checkOutput("short_counter",   32'(counter),   32'd0);

        $display("[TB] header-mismatch frame 7F_0042_01_3C");
        applyStimulus({40'h7F_0042_01_3C, 4'h0}, 40);
        repeat (4) @(negedge clk);
`ifdef SPI_RX_STRICT_HDR_EN
        exp_e++;
        checkOutput("hdr_err_code", 32'(err_code), 32'h2);
        checkOutput("hdr_addr",     32'(rx_addr),  32'h1234);
        checkOutput("hdr_data",     32'(rx_data),  32'hA5);
`else
        exp_v++;
        checkOutput("hdr_addr",     32'(rx_addr),  32'h0042);
        checkOutput("hdr_data",     32'(rx_data),  32'h3C);
`endif
        checkOutput("hdr_valid_cnt", 32'(valid_cnt), 32'(exp_v));
        checkOutput("hdr_error_cnt", 32'(error_cnt), 32'(exp_e));
        checkOutput("hdr_latency",   32'(last_lat),  32'(EXP_LAT));
        endFrame(6);

        $display("[TB] back-to-back frames");
        applyStimulus({40'hFF_0001_01_11, 4'h0}, 40);
        endFrame(2);
        applyStimulus({40'hFF_FFFF_01_EE, 4'h0}, 40);
        endFrame(8);
        exp_v += 2;
        checkOutput("b2b_valid_cnt", 32'(valid_cnt), 32'(exp_v));
        checkOutput("b2b_error_cnt", 32'(error_cnt), 32'(exp_e));
        checkOutput("b2b_addr0",     32'(vaddr[exp_v-2]), 32'h0001);
        checkOutput("b2b_data0",     32'(vdata[exp_v-2]), 32'h11);
        checkOutput("b2b_addr1",     32'(vaddr[exp_v-1]), 32'hFFFF);
        checkOutput("b2b_data1",     32'(vdata[exp_v-1]), 32'hEE);

        $display("[TB] 44 sclk edges in one frame");
        applyStimulus({40'hFF_5A5A_01_C3, 4'hF}, 44);
        repeat (2) @(negedge clk);
        exp_v++;
        checkOutput("long_count_40",  32'(counter),   32'd40);
        checkOutput("long_valid_cnt", 32'(valid_cnt), 32'(exp_v));
        checkOutput("long_error_cnt", 32'(error_cnt), 32'(exp_e));
        checkOutput("long_addr",      32'(rx_addr),   32'h5A5A);
        checkOutput("long_data",      32'(rx_data),   32'hC3);
        endFrame(6);

        $display("[TB] reset at bit 25, then frame FF_ABCD_01_55");
        applyStimulus({40'hFF_DEAD_01_77, 4'h0}, 25);
        reset = 1'b1;
        #1;
        checkOutput("rst_mid_counter", 32'(counter), 32'd0);
        checkOutput("rst_mid_addr",    32'(rx_addr), 32'h0);
        spi_cs_l = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("rst_no_pulse_v", 32'(valid_cnt), 32'(exp_v));
        checkOutput("rst_no_pulse_e", 32'(error_cnt), 32'(exp_e));
        applyStimulus({40'hFF_ABCD_01_55, 4'h0}, 40);
        endFrame(8);
        exp_v++;
        checkOutput("rst_valid_cnt", 32'(valid_cnt), 32'(exp_v));
        checkOutput("rst_error_cnt", 32'(error_cnt), 32'(exp_e));
        checkOutput("rst_addr",      32'(rx_addr),   32'hABCD);
        checkOutput("rst_data",      32'(rx_data),   32'h55);
        checkOutput("never_both",    32'(both_cnt),  32'd0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
